// File: rtl/spectrum_accum_ctrl.sv
// spectrum_accum_ctrl: read-modify-write bin accumulator with same-bin forwarding and clear sweep
// Ports: clk/rst_l (async active-low); in_valid/in_ready/in_bin/in_mag sample stream;
//   start_clear request, busy (DRAIN|CLEAR), clear_done pulse; SRAM read port 1
//   (sram_read_addr/sram_read_data) and write port (sram_we/sram_write_addr/sram_write_data);
//   sat_count saturation events, built only with `define SPECTRUM_ACCUM_SAT_COUNT_EN.
module spectrum_accum_ctrl #(
  parameter int NUM_WORDS  = 131072,
  parameter int WORD_WIDTH = 32,
  parameter int IN_WIDTH   = 16,
  parameter int ADDR_W     = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_bin,
  input  logic [IN_WIDTH-1:0]   in_mag,
  input  logic                  start_clear,
  output logic                  busy,
  output logic                  clear_done,
  output logic [ADDR_W-1:0]     sram_read_addr,
  input  logic [WORD_WIDTH-1:0] sram_read_data,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_write_addr,
  output logic [WORD_WIDTH-1:0] sram_write_data,
  output logic [15:0]           sat_count
);
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  state_e                state_q, state_d;
  logic                  s0_v_q, s0_v_d, s1_v_q, s1_v_d;
  logic [ADDR_W-1:0]     s0_bin_q, s0_bin_d, s1_bin_q, s1_bin_d;
  logic [IN_WIDTH-1:0]   s0_mag_q, s0_mag_d, s1_mag_q, s1_mag_d;
  logic [WORD_WIDTH-1:0] s1_old_q, s1_old_d;
  logic [ADDR_W-1:0]     clr_q, clr_d;
  logic                  done_q, done_d;
  logic                  hs, sat;
  logic [WORD_WIDTH:0]   wide;
  logic [WORD_WIDTH-1:0] sum;
  assign in_ready = rst_l && state_q == IDLE;
  assign hs = in_valid && in_ready;
  assign wide = {1'b0, s1_old_q} + (WORD_WIDTH + 1)'(s1_mag_q);
  assign sat = wide[WORD_WIDTH];
  assign sum = sat ? '1 : wide[WORD_WIDTH-1:0];
  assign sram_read_addr = s0_bin_q;
  assign sram_we = state_q == CLEAR || s1_v_q;
  assign sram_write_addr = state_q == CLEAR ? clr_q : s1_bin_q;
  assign sram_write_data = state_q == CLEAR ? '0 : sum;
  assign busy = state_q != IDLE;
  assign clear_done = done_q;
  always_comb begin
    state_d  = state_q;
    s0_v_d   = hs;
    s0_bin_d = hs ? in_bin : s0_bin_q;
    s0_mag_d = hs ? in_mag : s0_mag_q;
    s1_v_d   = s0_v_q;
    s1_bin_d = s0_bin_q;
    s1_mag_d = s0_mag_q;
    // the SRAM still holds the pre-update value while S1 writes the same bin, so take S1's sum
    s1_old_d = (s1_v_q && s1_bin_q == s0_bin_q) ? sum : sram_read_data;
    clr_d    = '0;
    done_d   = 1'b0;
    case (state_q)
      IDLE:  state_d = start_clear ? DRAIN : IDLE;
      DRAIN: state_d = (!s0_v_q && !s1_v_q) ? CLEAR : DRAIN;
      CLEAR: begin
        clr_d   = clr_q + ADDR_W'(1);
        state_d = clr_q == LAST ? IDLE : CLEAR;
        done_d  = clr_q == LAST;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      s0_v_q   <= 1'b0;
      s1_v_q   <= 1'b0;
      s0_bin_q <= '0;
      s0_mag_q <= '0;
      s1_bin_q <= '0;
      s1_mag_q <= '0;
      s1_old_q <= '0;
      clr_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s0_v_q   <= s0_v_d;
      s1_v_q   <= s1_v_d;
      s0_bin_q <= s0_bin_d;
      s0_mag_q <= s0_mag_d;
      s1_bin_q <= s1_bin_d;
      s1_mag_q <= s1_mag_d;
      s1_old_q <= s1_old_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
    end
  end
`ifdef SPECTRUM_ACCUM_SAT_COUNT_EN
  logic [15:0] sat_q, sat_d;
  always_comb begin
    sat_d = (state_q == IDLE && start_clear) ? '0 :
            (s1_v_q && sat && sat_q != 16'hFFFF) ? sat_q + 16'd1 : sat_q;
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) sat_q <= '0;
    else sat_q <= sat_d;
  end
  assign sat_count = sat_q;
`else
  assign sat_count = '0;
`endif
endmodule

// File: tb/tb_spectrum_accum_ctrl.sv
// tb_spectrum_accum_ctrl: randomized and directed checks of spectrum_accum_ctrl against a bin-total model
module tb_spectrum_accum_ctrl;
  localparam int N = 16;
  logic clk = 0, rst_l = 0, in_valid = 0, start_clear = 0;
  logic [3:0] in_bin = 0;
  logic [7:0] in_mag = 0;
  logic in_ready, busy, clear_done, sram_we;
  logic [3:0] sram_read_addr, sram_write_addr;
  logic [7:0] sram_read_data, sram_write_data;
  logic [15:0] sat_count;
  logic [7:0] mem [N];
  int exp_b [N];
  int exp_sat, vectors, errs, we_cnt;
  bit log_en;
  logic [11:0] wq[$];
  spectrum_accum_ctrl #(.NUM_WORDS(N), .WORD_WIDTH(8), .IN_WIDTH(8)) dut (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .in_mag(in_mag), .start_clear(start_clear), .busy(busy), .clear_done(clear_done),
    .sram_read_addr(sram_read_addr), .sram_read_data(sram_read_data), .sram_we(sram_we),
    .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data), .sat_count(sat_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) for (int i = 0; i < N; i++) mem[i] <= '0;
    else if (sram_we) mem[sram_write_addr] <= sram_write_data;
  end
  assign sram_read_data = mem[sram_read_addr];
  always @(posedge clk) begin
    if (rst_l && sram_we) begin
      we_cnt++;
      if (log_en) wq.push_back({sram_write_addr, sram_write_data});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_add(int b, int m);
    int s = exp_b[b] + m;
    if (s > 255) begin
      s = 255;
      if (exp_sat < 65535) exp_sat++;
    end
    exp_b[b] = s;
  endtask
  task automatic model_zero();
    for (int i = 0; i < N; i++) exp_b[i] = 0;
    exp_sat = 0;
  endtask
  function automatic int exp_satc();
`ifdef SPECTRUM_ACCUM_SAT_COUNT_EN
    return exp_sat;
`else
    return 0;
`endif
  endfunction
  task automatic send(int b, int m);
    in_valid = 1;
    in_bin = 4'(b);
    in_mag = 8'(m);
    tick();
    model_add(b, m);
  endtask
  task automatic flush();
    in_valid = 0;
    repeat (3) tick();
  endtask
  task automatic test_reset();
    model_zero();
    rst_l = 0;
    #12;
    vectors += 2;
    if (in_ready !== 0) begin errs++; $display("FAIL reset_ready: got %0b expected 0", in_ready); end
    if ({busy, clear_done, sram_we, sram_read_addr, sram_write_addr, sram_write_data, sat_count} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got %0h expected 0", {busy, clear_done, sram_we, sram_read_addr, sram_write_addr, sram_write_data, sat_count});
    end
    @(negedge clk);
    rst_l = 1;
    #1;
    vectors++;
    if ({in_ready, busy} !== 2'b10) begin errs++; $display("FAIL reset_release: got %b expected 10", {in_ready, busy}); end
    tick();
  endtask
  task automatic test_basic();
    int we0 = we_cnt;
    send(3, 5);
    vectors++;
    if (sram_we !== 0) begin errs++; $display("FAIL basic_we0: got %0b expected 0", sram_we); end
    send(7, 2);
    in_valid = 0;
    vectors++;
    if ({sram_we, sram_write_addr, sram_write_data} !== {1'b1, 4'd3, 8'd5}) begin
      errs++; $display("FAIL basic_wr3: got %0h expected %0h", {sram_we, sram_write_addr, sram_write_data}, {1'b1, 4'd3, 8'd5});
    end
    tick();
    vectors++;
    if ({sram_we, sram_write_addr, sram_write_data} !== {1'b1, 4'd7, 8'd2}) begin
      errs++; $display("FAIL basic_wr7: got %0h expected %0h", {sram_we, sram_write_addr, sram_write_data}, {1'b1, 4'd7, 8'd2});
    end
    tick();
    vectors += 2;
    if (sram_we !== 0) begin errs++; $display("FAIL basic_we_end: got %0b expected 0", sram_we); end
    if (we_cnt - we0 != 2) begin errs++; $display("FAIL basic_we_cycles: got %0d expected 2", we_cnt - we0); end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (mem[i] !== 8'(exp_b[i])) begin errs++; $display("FAIL basic_bin%0d: got %0d expected %0d", i, mem[i], exp_b[i]); end
    end
  endtask
  task automatic test_back_to_back();
    for (int m = 1; m <= 4; m++) begin
      vectors++;
      if (in_ready !== 1) begin errs++; $display("FAIL b2b_ready: got %0b expected 1", in_ready); end
      send(9, m);
    end
    flush();
    vectors++;
    if (mem[9] !== 8'd10) begin errs++; $display("FAIL b2b_bin9: got %0d expected 10", mem[9]); end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (mem[i] !== 8'(exp_b[i])) begin errs++; $display("FAIL b2b_bin%0d: got %0d expected %0d", i, mem[i], exp_b[i]); end
    end
  endtask
  task automatic test_alternate();
    send(2, 10);
    send(5, 1);
    send(2, 7);
    flush();
    vectors += 2;
    if (mem[2] !== 8'd17) begin errs++; $display("FAIL alt_bin2: got %0d expected 17", mem[2]); end
    if (mem[5] !== 8'd1) begin errs++; $display("FAIL alt_bin5: got %0d expected 1", mem[5]); end
  endtask
  task automatic test_saturation();
    send(0, 200);
    send(0, 100);
    flush();
    vectors += 2;
    if (mem[0] !== 8'd255) begin errs++; $display("FAIL sat_bin0: got %0d expected 255", mem[0]); end
    if (sat_count !== 16'(exp_satc())) begin errs++; $display("FAIL sat_count: got %0d expected %0d", sat_count, exp_satc()); end
  endtask
  task automatic test_clear();
    logic [11:0] eq[$];
    int done_cnt = 0, busy_bad = 0;
    wq.delete();
    log_en = 1;
    send(4, 3);
    eq.push_back({4'd4, 8'(exp_b[4])});
    send(4, 4);
    eq.push_back({4'd4, 8'(exp_b[4])});
    for (int a = 0; a < N; a++) eq.push_back({4'(a), 8'd0});
    in_valid = 0;
    start_clear = 1;
    vectors++;
    if (busy !== 0) begin errs++; $display("FAIL clear_busy_req: got %0b expected 0", busy); end
    tick();
    start_clear = 0;
    model_zero();
    for (int c = 0; c < 40; c++) begin
      if (clear_done === 1) done_cnt++;
      if (done_cnt == 0 && (busy !== 1 || in_ready !== 0)) busy_bad++;
      if (done_cnt > 0 && busy !== 0) busy_bad++;
      tick();
    end
    log_en = 0;
    vectors += 3;
    if (done_cnt != 1) begin errs++; $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt); end
    if (busy_bad != 0) begin errs++; $display("FAIL clear_busy: got %0d bad cycles expected 0", busy_bad); end
    if (wq.size() != eq.size()) begin errs++; $display("FAIL clear_writes: got %0d expected %0d", wq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== eq[i]) begin errs++; $display("FAIL clear_wr%0d: got %0h expected %0h", i, wq[i], eq[i]); end
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (mem[i] !== 8'(exp_b[i])) begin errs++; $display("FAIL clear_bin%0d: got %0d expected %0d", i, mem[i], exp_b[i]); end
    end
    vectors++;
    if (sat_count !== 16'(exp_satc())) begin errs++; $display("FAIL clear_sat: got %0d expected %0d", sat_count, exp_satc()); end
  endtask
  task automatic test_random();
    int b = 0;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(3) != 0) begin
        b = ($urandom_range(2) == 0) ? b : int'($urandom_range(N - 1));
        send(b, int'($urandom_range(255)));
      end else begin
        in_valid = 0;
        tick();
      end
    end
    flush();
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (mem[i] !== 8'(exp_b[i])) begin errs++; $display("FAIL rand_bin%0d: got %0d expected %0d", i, mem[i], exp_b[i]); end
    end
    vectors++;
    if (sat_count !== 16'(exp_satc())) begin errs++; $display("FAIL rand_sat: got %0d expected %0d", sat_count, exp_satc()); end
  endtask
  task automatic test_reset_mid_clear();
    bit found = 0;
    start_clear = 1;
    tick();
    start_clear = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (sram_we === 1 && sram_write_addr === 4'd6 && busy === 1) found = 1;
      else tick();
    end
    vectors++;
    if (!found) begin errs++; $display("FAIL midclr_reach6: got 0 expected 1"); end
    #2;
    rst_l = 0;
    #1;
    model_zero();
    vectors++;
    if ({in_ready, busy, clear_done, sram_we, sram_read_addr, sram_write_addr, sram_write_data, sat_count} !== '0) begin
      errs++;
      $display("FAIL midclr_reset: got %0h expected 0", {in_ready, busy, clear_done, sram_we, sram_read_addr, sram_write_addr, sram_write_data, sat_count});
    end
    repeat (2) @(negedge clk);
    rst_l = 1;
    #1;
    vectors++;
    if ({in_ready, busy} !== 2'b10) begin errs++; $display("FAIL midclr_release: got %b expected 10", {in_ready, busy}); end
    tick();
    vectors++;
    if ({in_ready, busy, clear_done, sram_we} !== 4'b1000) begin errs++; $display("FAIL midclr_idle: got %b expected 1000", {in_ready, busy, clear_done, sram_we}); end
    send(6, 9);
    send(6, 1);
    flush();
    vectors++;
    if (mem[6] !== 8'(exp_b[6])) begin errs++; $display("FAIL midclr_bin6: got %0d expected %0d", mem[6], exp_b[6]); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_alternate();
    test_saturation();
    test_clear();
    test_random();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/spectrum_accum_ctrl.md
Name: spectrum_accum_ctrl

Overview:
- Read-modify-write controller that accumulates magnitude samples into per-bin totals held in the dual-read/single-write bin SRAM of the double-bandwidth spectrum path.
- Owns SRAM read port 1 and the write port. Read port 2 stays free for host readout in the parent.
- Sustains one sample per clock, forwards results on back-to-back same-bin hazards, and runs a clear sweep on request.

Parameters:
- NUM_WORDS, 131072, number of bins (SRAM depth); ADDR_W = $clog2(NUM_WORDS)
- WORD_WIDTH, 32, accumulator and SRAM word width
- IN_WIDTH, 16, magnitude sample width; must be <= WORD_WIDTH

Ports:
- clk  input  1  clock
- rst_l  input  1  asynchronous active-low reset
- in_valid  input  1  sample valid
- in_ready  output  1  controller accepts sample
- in_bin  input  ADDR_W  target bin
- in_mag  input  IN_WIDTH  unsigned magnitude
- start_clear  input  1  single-cycle request to zero all bins
- busy  output  1  high in DRAIN or CLEAR
- clear_done  output  1  one-cycle pulse when sweep completes
- sram_read_addr  output  ADDR_W  to SRAM read_addr_1
- sram_read_data  input  WORD_WIDTH  from SRAM read_data_1 (combinational read)
- sram_we  output  1  to SRAM we
- sram_write_addr  output  ADDR_W  to SRAM write_addr
- sram_write_data  output  WORD_WIDTH  to SRAM write_data
- sat_count  output  16  saturation event count (see Optional Feature)

Behaviour:
- Reset: state IDLE, both pipeline valids 0, in_ready=0 while rst_l low and 1 after reset; busy=0, clear_done=0, sram_we=0, all address and data outputs 0, sat_count=0.
- FSM IDLE: in_ready=1; a handshake occurs when in_valid && in_ready.
- FSM IDLE -> DRAIN on start_clear. DRAIN: in_ready=0, busy=1.
- FSM DRAIN -> CLEAR once both pipeline stages are invalid.
- FSM CLEAR: in_ready=0, busy=1. Writes 0 to addresses 0,1,...,NUM_WORDS-1, one per cycle (sram_we=1).
- FSM CLEAR -> IDLE in the cycle after the write to NUM_WORDS-1. clear_done pulses for exactly that one cycle.
- start_clear while in DRAIN or CLEAR is ignored.
- Pipeline S0: the handshake at edge E registers bin and mag. During the following cycle S0 drives sram_read_addr=bin.
- Pipeline S1: at edge E+1, captures bin, mag and old value. Old value is sram_read_data, except when S1 is valid with an equal bin; then the old value is S1's sum (forwarding).
- Pipeline S1 output: combinationally, sum = old + zero-extended mag, saturating at 2^WORD_WIDTH-1. While S1 is valid, sram_we=1, sram_write_addr=S1 bin, sram_write_data=sum.
- Latency: SRAM holds the updated value after edge E+2.
- Throughput: one sample per cycle. Any pattern of consecutive same-bin samples gives exact totals, with no stall.
- In CLEAR, the sweep drives the write port. S1 is empty there because DRAIN guarantees it.
- sram_read_addr holds its last value when S0 is invalid.
- Reset mid-operation (asynchronous) discards the in-flight pipeline and any sweep in progress, and returns to IDLE. The SRAM is reset separately by the same rst_l.

Optional Feature:
- Macro: SPECTRUM_ACCUM_SAT_COUNT_EN.
- When defined: sat_count increments by 1 for each S1 write whose add saturated. It holds at 16'hFFFF and clears to 0 on entering DRAIN.
- When not defined: sat_count is tied to 0 and no counter logic is built.

Test Plan:
- NUM_WORDS=16: reset, then samples (bin 3, mag 5), (bin 7, mag 2) on consecutive cycles -> after 2 edges, bin3=5 and bin7=2; sram_we high exactly 2 cycles.
- Back-to-back same bin: 4 consecutive samples to bin 9 with mag 1,2,3,4 -> bin9=10. Forwarding is exercised 3 times. in_ready stays 1 throughout.
- Alternating A/B/A: bin 2 mag 10, bin 5 mag 1, bin 2 mag 7 -> bin2=17, bin5=1.
- Saturation with WORD_WIDTH=8, IN_WIDTH=8: bin 0 receives 200 then 100 -> bin0=255. With the macro defined sat_count=1; without it sat_count=0.
- Clear: start_clear pulsed while 2 samples are in flight -> both writes complete, then 16 zero writes to addresses 0..15. clear_done pulses once. busy is high from the cycle after start_clear until the clear_done cycle. All bins read back 0.
- rst_l asserted mid-CLEAR at address 6 -> all outputs take reset values immediately. After release, state is IDLE and in_ready=1.
